// File: rtl/icache_axi_rd_bridge_pkg.sv
// Shared definitions for the I-cache AXI4 read bridge: FSM states and AXI burst constants.
package icache_axi_rd_bridge_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    AR_LINE = 3'd1,
    R_LINE  = 3'd2,
    AR_UNC  = 3'd3,
    R_UNC   = 3'd4,
    RET     = 3'd5
  } state_t;

  localparam logic [1:0] INCR    = 2'b01;
  localparam logic [2:0] SIZE_4B = 3'b010;

  // Refill bursts always start on a 16-byte boundary.
  function automatic logic [31:0] line_align(input logic [31:0] addr);
    return {addr[31:4], 4'h0};
  endfunction

endpackage

// File: rtl/icache_axi_rd_bridge_if.sv
// AXI4 read-address and read-data channels between the bridge (master) and memory (slave).
interface icache_axi_rd_bridge_if;

  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready;

  modport master (
    output arid, araddr, arlen, arsize, arburst, arvalid, rready,
    input  arready, rdata, rresp, rlast, rvalid
  );

  modport slave (
    input  arid, araddr, arlen, arsize, arburst, arvalid, rready,
    output arready, rdata, rresp, rlast, rvalid
  );

endinterface

// File: rtl/icache_axi_rd_bridge.sv
// Turns I-cache line refills and uncached word fetches into single AXI4 read transactions,
// one outstanding at a time; line requests win over uncached ones when both arrive together.
module icache_axi_rd_bridge
  import icache_axi_rd_bridge_pkg::*;
#(
  parameter int         LINE_WORD_NUM = 4,
  parameter logic [3:0] AXI_ID        = 4'd0
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic                          line_rd_req,
  input  logic [31:0]                   line_rd_addr,
  output logic                          line_rd_rdy,
  output logic                          line_ret_valid,
  output logic [32*LINE_WORD_NUM-1:0]   line_ret_data,
  input  logic                          unc_rd_req,
  input  logic [31:0]                   unc_rd_addr,
  output logic                          unc_rd_rdy,
  output logic                          unc_ret_valid,
  output logic [31:0]                   unc_ret_data,
  icache_axi_rd_bridge_if.master        axi
);

  localparam int         BEAT_W     = (LINE_WORD_NUM > 1) ? $clog2(LINE_WORD_NUM) : 1;
  localparam logic [7:0] ARLEN_LINE = 8'(LINE_WORD_NUM - 1);
  localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(LINE_WORD_NUM - 1);

  state_t                        state_r;
  logic [BEAT_W-1:0]             beat_cnt_r;
  logic [31:0]                   addr_r;
  logic [7:0]                    arlen_r;
  logic                          arvalid_r;
  logic                          rready_r;
  logic                          line_rdy_r;
  logic                          unc_rdy_r;
  logic                          line_ret_valid_r;
  logic                          unc_ret_valid_r;
  logic [32*LINE_WORD_NUM-1:0]   line_buf_r;
  logic [31:0]                   unc_data_r;
  logic                          unused_bits;

  // Error responses are not reported and the line address low nibble is forced to zero.
  assign unused_bits = ^{line_rd_addr[3:0], axi.rresp};

  // Request arbitration, AXI handshakes, beat capture and return pulses.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_r          <= IDLE;
      beat_cnt_r       <= '0;
      addr_r           <= 32'h0000_0000;
      arlen_r          <= 8'h00;
      arvalid_r        <= 1'b0;
      rready_r         <= 1'b0;
      line_rdy_r       <= 1'b1;
      unc_rdy_r        <= 1'b1;
      line_ret_valid_r <= 1'b0;
      unc_ret_valid_r  <= 1'b0;
      line_buf_r       <= '0;
      unc_data_r       <= 32'h0000_0000;
    end else begin
      line_ret_valid_r <= 1'b0;
      unc_ret_valid_r  <= 1'b0;
      case (state_r)
        IDLE: begin
          if (line_rd_req && line_rdy_r) begin
            state_r    <= AR_LINE;
            addr_r     <= line_align(line_rd_addr);
            arlen_r    <= ARLEN_LINE;
            arvalid_r  <= 1'b1;
            line_rdy_r <= 1'b0;
            unc_rdy_r  <= 1'b0;
          end else if (unc_rd_req && unc_rdy_r) begin
            state_r    <= AR_UNC;
            addr_r     <= unc_rd_addr;
            arlen_r    <= 8'h00;
            arvalid_r  <= 1'b1;
            line_rdy_r <= 1'b0;
            unc_rdy_r  <= 1'b0;
          end else begin
            state_r <= IDLE;
          end
        end
        AR_LINE, AR_UNC: begin
          if (axi.arready) begin
            state_r   <= (state_r == AR_LINE) ? R_LINE : R_UNC;
            arvalid_r <= 1'b0;
            rready_r  <= 1'b1;
          end else begin
            state_r <= state_r;
          end
        end
        R_LINE: begin
          if (axi.rvalid) begin
            line_buf_r[{beat_cnt_r, 5'd0} +: 32] <= axi.rdata;
            // rlast ends the burst even if the slot counter disagrees.
            if (axi.rlast) begin
              beat_cnt_r       <= '0;
              state_r          <= RET;
              rready_r         <= 1'b0;
              line_ret_valid_r <= 1'b1;
            end else begin
              beat_cnt_r <= (beat_cnt_r == BEAT_LAST) ? '0 : beat_cnt_r + BEAT_W'(1);
            end
          end else begin
            state_r <= R_LINE;
          end
        end
        R_UNC: begin
          if (axi.rvalid) begin
            unc_data_r      <= axi.rdata;
            state_r         <= RET;
            rready_r        <= 1'b0;
            unc_ret_valid_r <= 1'b1;
          end else begin
            state_r <= R_UNC;
          end
        end
        RET: begin
          state_r    <= IDLE;
          line_rdy_r <= 1'b1;
          unc_rdy_r  <= 1'b1;
        end
        default: begin
          state_r    <= IDLE;
          arvalid_r  <= 1'b0;
          rready_r   <= 1'b0;
          line_rdy_r <= 1'b1;
          unc_rdy_r  <= 1'b1;
        end
      endcase
    end
  end

  assign line_rd_rdy    = line_rdy_r;
  assign unc_rd_rdy     = unc_rdy_r;
  assign line_ret_valid = line_ret_valid_r;
  assign unc_ret_valid  = unc_ret_valid_r;
  assign line_ret_data  = line_buf_r;
  assign unc_ret_data   = unc_data_r;

  assign axi.arid    = AXI_ID;
  assign axi.araddr  = addr_r;
  assign axi.arlen   = arlen_r;
  assign axi.arsize  = SIZE_4B;
  assign axi.arburst = INCR;
  assign axi.arvalid = arvalid_r;
  assign axi.rready  = rready_r;

endmodule
